tlp_demux_n: RTL and testbench

TLP_DEMUX_N -- requirements
Module: tlp_demux_n

---
 rtl/tlp_demux_n_pkg.sv | 33 +++
 rtl/tlp_demux_n_if.sv | 37 +++
 rtl/tlp_route_decode.sv | 44 ++++
 rtl/tlp_demux_n.sv | 135 +++++++++++++
 tb/tb_tlp_demux_n.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlp_demux_n_pkg.sv
// Shared definitions for the TLP demultiplexer.
// Holds the DW0 fmt/type field positions, the routed type codes, the
// destination port indices and the FSM state type.
package tlp_demux_n_pkg;

  // DW0 field positions inside the header bus
  localparam int unsigned FmtMsb   = 31;
  localparam int unsigned FmtLsb   = 29;
  localparam int unsigned TypeMsb  = 28;
  localparam int unsigned TypeLsb  = 24;
  // fmt bit that separates writes (with data) from reads
  localparam int unsigned FmtWrBit = 1;

  // Type codes; MRd and MWr share a code and differ only in fmt
  localparam logic [4:0] TypeMrd    = 5'b00000;
  localparam logic [4:0] TypeMwr    = 5'b00000;
  localparam logic [4:0] TypeCpl    = 5'b01010;
  localparam logic [1:0] TypeMsgPfx = 2'b10;

  typedef logic [1:0] port_idx_t;

  localparam port_idx_t PortMrd = 2'd0;
  localparam port_idx_t PortMwr = 2'd1;
  localparam port_idx_t PortCpl = 2'd2;
  localparam port_idx_t PortMsg = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StDrop
  } state_e;

endpackage

// File: rtl/tlp_demux_n_if.sv
// Beat-stream bundle for the TLP demultiplexer.
// in_*  : single input stream (data, header, sop/eop framing, valid/ready).
// out_* : PORTS output streams flattened, port p in slice p.
// master: the side that sources in_* and sinks out_*; slave: the demux.
interface tlp_demux_n_if
  import tlp_demux_n_pkg::*;
#(
  parameter int unsigned PORTS          = 3,
  parameter int unsigned HEADER_SIZE    = 128,
  parameter int unsigned TLP_DATA_WIDTH = 256
);

  logic [TLP_DATA_WIDTH-1:0]       in_data;
  logic [HEADER_SIZE-1:0]          in_hdr;
  logic                            in_sop;
  logic                            in_eop;
  logic                            in_valid;
  logic                            in_ready;

  logic [PORTS*TLP_DATA_WIDTH-1:0] out_data;
  logic [PORTS*HEADER_SIZE-1:0]    out_hdr;
  logic [PORTS-1:0]                out_sop;
  logic [PORTS-1:0]                out_eop;
  logic [PORTS-1:0]                out_valid;
  logic [PORTS-1:0]                out_ready;

  modport master (
    output in_data, in_hdr, in_sop, in_eop, in_valid, out_ready,
    input  in_ready, out_data, out_hdr, out_sop, out_eop, out_valid
  );

  modport slave (
    input  in_data, in_hdr, in_sop, in_eop, in_valid, out_ready,
    output in_ready, out_data, out_hdr, out_sop, out_eop, out_valid
  );

endinterface

// File: rtl/tlp_route_decode.sv
// Combinational header classifier.
// dw0   : first header DW (fmt/type live in bits 31:24).
// port  : destination port index for the header's class.
// match : class is routable and its port exists in this build.
module tlp_route_decode
  import tlp_demux_n_pkg::*;
#(
  parameter int unsigned PORTS = 3
) (
  input  logic [31:0] dw0,
  output port_idx_t   port,
  output logic        match
);

  logic [2:0] fmt;
  logic [4:0] tlp_type;
  logic       known;
  logic       unused_dw0;

  assign fmt        = dw0[FmtMsb:FmtLsb];
  assign tlp_type   = dw0[TypeMsb:TypeLsb];
  assign unused_dw0 = ^{dw0[TypeLsb-1:0], fmt[2], fmt[0]};

  always_comb begin
    port  = PortMrd;
    known = 1'b0;
    if (tlp_type == TypeMrd && !fmt[FmtWrBit]) begin
      port  = PortMrd;
      known = 1'b1;
    end else if (tlp_type == TypeMwr && fmt[FmtWrBit]) begin
      port  = PortMwr;
      known = 1'b1;
    end else if (tlp_type == TypeCpl) begin
      port  = PortCpl;
      known = 1'b1;
    end else if (tlp_type[4:3] == TypeMsgPfx) begin
      port  = PortMsg;
      known = 1'b1;
    end
    // classes mapped beyond the configured port count are dropped
    match = known && ({30'd0, port} < PORTS);
  end

endmodule

// File: rtl/tlp_demux_n.sv
// TLP demultiplexer: routes packets from one beat stream to PORTS outputs
// by header class, drops unroutable packets and flags framing errors.
// clk/rst_n  : rising-edge clock, synchronous active-low reset.
// enable     : allow new packets to start (never truncates one in flight).
// bus        : input stream and per-port output streams (one register stage).
// drop_cnt   : saturating count of dropped packets.
// tlp_error  : one-cycle pulse on a drop or a framing error.
module tlp_demux_n
  import tlp_demux_n_pkg::*;
#(
  parameter int unsigned PORTS          = 3,
  parameter int unsigned DOUBLE_WORD    = 32,
  parameter int unsigned HEADER_SIZE    = 4 * DOUBLE_WORD,
  parameter int unsigned TLP_DATA_WIDTH = 8 * DOUBLE_WORD,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  tlp_demux_n_if.slave         bus,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic                 tlp_error
);

  state_e                               state_q;
  port_idx_t                            sel_q;
  logic [HEADER_SIZE-1:0]               hdr_q;
  logic [PORTS-1:0]                     valid_q, sop_q, eop_q;
  logic [PORTS-1:0][TLP_DATA_WIDTH-1:0] data_q;
  logic [PORTS-1:0][HEADER_SIZE-1:0]    ohdr_q;
  logic [CNT_WIDTH-1:0]                 drop_q;
  logic                                 err_q;

  port_idx_t              dec_port, cur_port;
  logic                   dec_match, cur_fwd, allow, port_free, others_free;
  logic                   ready, accept;
  logic [HEADER_SIZE-1:0] beat_hdr;

  tlp_route_decode #(
    .PORTS(PORTS)
  ) u_decode (
    .dw0  (bus.in_hdr[31:0]),
    .port (dec_port),
    .match(dec_match)
  );

  always_comb begin
    allow       = rst_n & ((state_q != StIdle) | enable);
    // a sop beat is always (re)classified; other beats follow the latched route
    cur_port    = bus.in_sop ? dec_port : sel_q;
    cur_fwd     = bus.in_sop ? dec_match : (state_q == StFwd);
    port_free   = 1'b1;
    others_free = 1'b1;
    for (int p = 0; p < PORTS; p++) begin
      if (port_idx_t'(p) == cur_port) begin
        port_free = !valid_q[p] | bus.out_ready[p];
      end else begin
        // a port switch also waits for the old port to drain, keeping out_valid one-hot
        others_free = others_free & (!valid_q[p] | bus.out_ready[p]);
      end
    end
    ready    = allow & (!cur_fwd | (port_free & others_free));
    accept   = bus.in_valid & ready;
    beat_hdr = bus.in_sop ? bus.in_hdr : hdr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= PortMrd;
      hdr_q   <= '0;
      valid_q <= '0;
      sop_q   <= '0;
      eop_q   <= '0;
      data_q  <= '0;
      ohdr_q  <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;

      for (int p = 0; p < PORTS; p++) begin
        if (accept && cur_fwd && port_idx_t'(p) == cur_port) begin
          valid_q[p] <= 1'b1;
          sop_q[p]   <= bus.in_sop;
          eop_q[p]   <= bus.in_eop;
          data_q[p]  <= bus.in_data;
          ohdr_q[p]  <= beat_hdr;
        end else if (bus.out_ready[p]) begin
          // an idle port always presents zeros
          valid_q[p] <= 1'b0;
          sop_q[p]   <= 1'b0;
          eop_q[p]   <= 1'b0;
          data_q[p]  <= '0;
          ohdr_q[p]  <= '0;
        end
      end

      if (accept) begin
        if (bus.in_sop) begin
          hdr_q <= bus.in_hdr;
          sel_q <= dec_port;
          if (state_q != StIdle) begin
            err_q <= 1'b1;
          end
          if (!dec_match) begin
            err_q <= 1'b1;
            if (drop_q != {CNT_WIDTH{1'b1}}) begin
              drop_q <= drop_q + CNT_WIDTH'(1);
            end
          end
          if (bus.in_eop) begin
            state_q <= StIdle;
          end else begin
            state_q <= dec_match ? StFwd : StDrop;
          end
        end else if (state_q == StIdle) begin
          err_q <= 1'b1;
        end else if (bus.in_eop) begin
          state_q <= StIdle;
        end
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.out_sop   = sop_q;
  assign bus.out_eop   = eop_q;
  assign bus.out_data  = data_q;
  assign bus.out_hdr   = ohdr_q;
  assign drop_cnt      = drop_q;
  assign tlp_error     = err_q;

endmodule

// File: tb/tb_tlp_demux_n.sv
// Bench for tlp_demux_n: packet-level reference model with per-port
// expected-beat queues, directed scenarios followed by a randomized phase.
module tb_tlp_demux_n;

  localparam int unsigned HS = 128;
  localparam int unsigned TW = 256;
  localparam int unsigned CW = 16;
  localparam int unsigned NP = 3;

  typedef struct packed {
    logic [TW-1:0] data;
    logic [HS-1:0] hdr;
    logic          sop;
    logic          eop;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, enable, enable2;
  logic [CW-1:0] drop_cnt, drop_cnt2;
  logic          tlp_error, tlp_error2;

  tlp_demux_n_if #(.PORTS(NP), .HEADER_SIZE(HS), .TLP_DATA_WIDTH(TW)) bus ();
  tlp_demux_n_if #(.PORTS(2), .HEADER_SIZE(HS), .TLP_DATA_WIDTH(TW)) bus2 ();

  tlp_demux_n #(.PORTS(NP)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus),
    .drop_cnt(drop_cnt), .tlp_error(tlp_error)
  );

  tlp_demux_n #(.PORTS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable2), .bus(bus2),
    .drop_cnt(drop_cnt2), .tlp_error(tlp_error2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  beat_t         src_q[$];
  beat_t         exp_q[NP][$];
  beat_t         cur = '0;
  bit            have_beat = 0;
  bit            in_pkt = 0;
  int            cur_dest = -1;
  logic [HS-1:0] cur_hdr = '0;
  logic [CW-1:0] drop_exp = '0;
  bit            err_exp = 0;
  int            dlv[NP];
  int            err_seen = 0;
  int            acc_cnt = 0;
  int            rdy_mode = 0;
  bit            en_val = 1;
  int            gap_pct = 0;

  task automatic chk(string tag, logic [TW-1:0] obs, logic [TW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [HS-1:0] rnd_hdr();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [TW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Destination from the routing table; -1 means the packet is dropped
  function automatic int route(logic [HS-1:0] h, int ports);
    logic [2:0] fmt;
    logic [4:0] t;
    int d;
    fmt = h[31:29];
    t   = h[28:24];
    d   = -1;
    if (t == 5'b00000)         d = fmt[1] ? 1 : 0;
    else if (t == 5'b01010)    d = 2;
    else if (t[4:3] == 2'b10)  d = 3;
    if (d >= ports) d = -1;
    return d;
  endfunction

  function automatic bit busy();
    return src_q.size() > 0 || have_beat ||
           (exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) > 0;
  endfunction

  task automatic push_pkt(logic [2:0] fmt, logic [4:0] typ, int len, bit no_eop = 0);
    beat_t b;
    logic [HS-1:0] h;
    h = rnd_hdr();
    h[31:29] = fmt;
    h[28:24] = typ;
    for (int i = 0; i < len; i++) begin
      b.data = rnd_data();
      b.hdr  = (i == 0) ? h : rnd_hdr();
      b.sop  = (i == 0);
      b.eop  = (i == len - 1) && !no_eop;
      src_q.push_back(b);
    end
  endtask

  task automatic model_accept(beat_t b);
    beat_t e;
    acc_cnt++;
    if (b.sop) begin
      if (in_pkt) err_exp = 1;
      cur_dest = route(b.hdr, NP);
      cur_hdr  = b.hdr;
      if (cur_dest < 0) begin
        err_exp = 1;
        if (drop_exp != '1) drop_exp++;
      end else begin
        e = '{data: b.data, hdr: b.hdr, sop: 1'b1, eop: b.eop};
        exp_q[cur_dest].push_back(e);
      end
      in_pkt = !b.eop;
    end else if (!in_pkt) begin
      err_exp = 1;
    end else begin
      if (cur_dest >= 0) begin
        e = '{data: b.data, hdr: cur_hdr, sop: 1'b0, eop: b.eop};
        exp_q[cur_dest].push_back(e);
      end
      if (b.eop) in_pkt = 0;
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    src_q.delete();
    have_beat = 0;
    in_pkt    = 0;
    cur_dest  = -1;
    drop_exp  = '0;
    err_exp   = 0;
  endtask

  // One clock: drive at the falling edge, check 1ns later, then book the
  // handshakes that complete on the following rising edge.
  task automatic step(bit rst_val = 1'b1);
    beat_t e;
    logic [NP-1:0] ordy;
    @(negedge clk);
    rst_n = rst_val;
    if (!have_beat && src_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
      cur = src_q.pop_front();
      have_beat = 1;
    end
    bus.in_valid = have_beat;
    bus.in_data  = cur.data;
    bus.in_hdr   = cur.hdr;
    bus.in_sop   = have_beat && cur.sop;
    bus.in_eop   = have_beat && cur.eop;
    ordy = '1;
    if (rdy_mode == 1) ordy = NP'($urandom);
    else if (rdy_mode == 2) ordy[1] = ~bus.out_ready[1];
    bus.out_ready = ordy;
    enable = en_val;
    #1;
    if (!rst_val) begin
      chk("ready_in_reset", bus.in_ready, 0);
      model_reset();
      return;
    end
    chk("tlp_error", tlp_error, err_exp);
    if (tlp_error) err_seen++;
    err_exp = 0;
    chk("drop_cnt", drop_cnt, drop_exp);
    chk("onehot", $countones(bus.out_valid) <= 1, 1);
    if (!in_pkt && !enable) chk("ready_enable_low", bus.in_ready, 0);
    if (have_beat && !cur.sop && in_pkt && cur_dest >= 0 &&
        bus.out_valid[cur_dest] && !bus.out_ready[cur_dest])
      chk("ready_backpressure", bus.in_ready, 0);
    for (int p = 0; p < NP; p++) begin
      if (bus.out_valid[p]) begin
        if (bus.out_ready[p]) begin
          if (exp_q[p].size() == 0) begin
            chk($sformatf("extra_beat_p%0d", p), exp_q[p].size(), 1);
          end else begin
            e = exp_q[p].pop_front();
            chk($sformatf("data_p%0d", p), bus.out_data[p*TW +: TW], e.data);
            chk($sformatf("hdr_p%0d", p), bus.out_hdr[p*HS +: HS], e.hdr);
            chk($sformatf("sop_eop_p%0d", p), {bus.out_sop[p], bus.out_eop[p]}, {e.sop, e.eop});
            dlv[p]++;
          end
        end
      end else begin
        chk($sformatf("idle_data_p%0d", p), bus.out_data[p*TW +: TW], 0);
        chk($sformatf("idle_hdr_p%0d", p), bus.out_hdr[p*HS +: HS], 0);
        chk($sformatf("idle_sop_eop_p%0d", p), {bus.out_sop[p], bus.out_eop[p]}, 0);
      end
    end
    if (have_beat && bus.in_ready) begin
      model_accept(cur);
      have_beat = 0;
    end
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", !busy(), 1);
    step();
    step();
  endtask

  initial begin
    int base, d0, d1, got, sel, len;
    bit ov2;
    logic [HS-1:0] h2;

    rst_n = 1'b0;
    enable = 1'b0;
    enable2 = 1'b1;
    bus.in_valid = 0; bus.in_sop = 0; bus.in_eop = 0; bus.in_data = '0; bus.in_hdr = '0;
    bus.out_ready = '1;
    bus2.in_valid = 0; bus2.in_sop = 0; bus2.in_eop = 0; bus2.in_data = '0; bus2.in_hdr = '0;
    bus2.out_ready = '1;
    for (int p = 0; p < NP; p++) dlv[p] = 0;

    // Reset state
    step(0);
    step(0);
    step();
    chk("reset_out_valid", bus.out_valid, 0);

    // MWr(3), MRd(1), CplD(2) with all ports ready
    push_pkt(3'b010, 5'b00000, 3);
    push_pkt(3'b000, 5'b00000, 1);
    push_pkt(3'b010, 5'b01010, 2);
    drain(100);
    chk("seq_beats_p1", dlv[1], 3);
    chk("seq_beats_p0", dlv[0], 1);
    chk("seq_beats_p2", dlv[2], 2);
    chk("seq_drop_cnt", drop_cnt, 0);

    // CfgRd0 is unroutable
    err_seen = 0;
    push_pkt(3'b000, 5'b00100, 2);
    drain(100);
    chk("cfg_err_pulses", err_seen, 1);
    chk("cfg_drop_cnt", drop_cnt, 1);
    chk("cfg_no_delivery", dlv[0] + dlv[1] + dlv[2], 6);

    // Port 1 ready toggling during a 4-beat MWr
    rdy_mode = 2;
    d1 = dlv[1];
    push_pkt(3'b011, 5'b00000, 4);
    drain(100);
    chk("toggle_beats_p1", dlv[1] - d1, 4);
    rdy_mode = 0;

    // enable drops after beat 2: packet completes, next sop is held
    base = acc_cnt;
    d0 = dlv[0];
    d1 = dlv[1];
    push_pkt(3'b010, 5'b00000, 4);
    push_pkt(3'b000, 5'b00000, 1);
    for (int n = 0; n < 50 && acc_cnt - base < 2; n++) step();
    en_val = 0;
    for (int n = 0; n < 50 && acc_cnt - base < 4; n++) step();
    chk("enable_low_pkt_done", acc_cnt - base, 4);
    for (int n = 0; n < 5; n++) step();
    chk("enable_low_sop_held", acc_cnt - base, 4);
    en_val = 1;
    drain(100);
    chk("enable_beats_p1", dlv[1] - d1, 4);
    chk("enable_beats_p0", dlv[0] - d0, 1);

    // Reset mid-packet, then a clean MRd
    base = acc_cnt;
    push_pkt(3'b010, 5'b00000, 4);
    for (int n = 0; n < 50 && acc_cnt - base < 2; n++) step();
    step(0);
    step();
    chk("post_reset_valid", bus.out_valid, 0);
    chk("post_reset_drop", drop_cnt, 0);
    chk("post_reset_err", tlp_error, 0);
    d0 = dlv[0];
    push_pkt(3'b001, 5'b00000, 1);
    drain(100);
    chk("post_reset_mrd_p0", dlv[0] - d0, 1);

    // Randomized traffic, including drops and framing errors
    rdy_mode = 1;
    gap_pct = 20;
    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(5);
      len = $urandom_range(1, 4);
      case (sel)
        0: push_pkt({2'b00, 1'($urandom)}, 5'b00000, len, $urandom_range(9) == 0);
        1: push_pkt({2'b01, 1'($urandom)}, 5'b00000, len, $urandom_range(9) == 0);
        2: push_pkt({1'b0, 1'($urandom), 1'b0}, 5'b01010, len, $urandom_range(9) == 0);
        3: push_pkt(3'b000, 5'b00100, len);
        4: push_pkt(3'b001, {2'b10, 3'($urandom)}, len);
        default: src_q.push_back('{data: rnd_data(), hdr: rnd_hdr(), sop: 1'b0,
                                   eop: 1'($urandom)});
      endcase
      en_val = ($urandom_range(3) != 0);
      for (int n = 0; n < len + 2; n++) step();
    end
    en_val = 1;
    drain(3000);
    rdy_mode = 0;
    gap_pct = 0;

    // Two-port build drops completions
    got = 0;
    ov2 = 0;
    h2 = rnd_hdr();
    h2[31:29] = 3'b010;
    h2[28:24] = 5'b01010;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus2.in_valid = 1;
      bus2.in_sop   = (i == 0);
      bus2.in_eop   = (i == 1);
      bus2.in_hdr   = h2;
      bus2.in_data  = rnd_data();
      #1;
      ov2 |= |bus2.out_valid;
      for (int n = 0; n < 20 && !bus2.in_ready; n++) begin
        @(negedge clk);
        #1;
        ov2 |= |bus2.out_valid;
      end
      if (bus2.in_ready) got++;
    end
    @(negedge clk);
    bus2.in_valid = 0;
    #1;
    ov2 |= |bus2.out_valid;
    chk("p2_cpl_accepted", got, 2);
    chk("p2_no_valid", ov2, 0);
    chk("p2_drop_cnt", drop_cnt2, 1);

    chk("final_queues_empty", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
